hamming74_encoder_proj: RTL and testbench

HAMMING74_ENCODER_PROJ -- requirements
Module: hamming74_encoder_proj

---
 rtl/hamming74_encoder_proj.sv | 116 +++++++++++
 tb/tb_hamming74_encoder_proj.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hamming74_encoder_proj.sv
// Hamming(7,4) encoder with an input FIFO of pre-encoded codewords and a
// single registered output stage (EMPTY/FULL) using valid/ready handshakes.
module hamming74_encoder_proj #(
  parameter int FIFO_DEPTH = 4,
  parameter int CNT_W      = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [3:0]       din,
  input  logic             din_valid,
  output logic             din_ready,
  input  logic             inj_en,
  input  logic [2:0]       inj_pos,
  output logic [6:0]       io_out,
  output logic             io_out_valid,
  input  logic             io_out_ready,
  output logic [CNT_W-1:0] frame_cnt,
  output logic             overflow
);

  // state   | meaning
  // S_EMPTY | output register holds no frame, io_out_valid=0
  // S_FULL  | output register holds an unconsumed frame, io_out_valid=1
  typedef enum logic {S_EMPTY, S_FULL} state_t;

  localparam int AW = $clog2(FIFO_DEPTH);

  logic [6:0]  mem [0:FIFO_DEPTH-1];
  logic [AW:0] wr_ptr, rd_ptr;
  logic        ready_en;
  logic        fifo_full, fifo_empty;
  logic        push, load, consume;
  logic [6:0]  code_in, flip_mask;
  logic [6:0]  out_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic        ovf_reg;
  state_t      state, state_next;

  // Codeword layout {d4,d3,d2,p3,d1,p2,p1}
  always_comb begin
    flip_mask = 7'b0;
    if (inj_en && (inj_pos != 3'd7)) flip_mask = 7'b1 << inj_pos;
    code_in = {din[3], din[2], din[1],
               din[1] ^ din[2] ^ din[3],
               din[0],
               din[0] ^ din[2] ^ din[3],
               din[0] ^ din[1] ^ din[3]} ^ flip_mask;
  end

  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // ready_en keeps din_ready low until the first edge after reset release
  assign din_ready  = ready_en && !fifo_full;
  assign push       = din_valid && din_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      ready_en <= 1'b0;
      ovf_reg  <= 1'b0;
    end else begin
      ready_en <= 1'b1;
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (load) rd_ptr <= rd_ptr + 1'b1;
      if (din_valid && fifo_full) ovf_reg <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= code_in;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_EMPTY;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    load       = 1'b0;
    consume    = 1'b0;
    case (state)
      S_EMPTY: begin
        if (!fifo_empty) begin
          load       = 1'b1;
          state_next = S_FULL;
        end
      end
      S_FULL: begin
        if (io_out_ready) begin
          consume = 1'b1;
          if (!fifo_empty) load = 1'b1;
          else             state_next = S_EMPTY;
        end
      end
      default: state_next = S_EMPTY;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_reg <= 7'b0;
      cnt_reg <= '0;
    end else begin
      if (load)    out_reg <= mem[rd_ptr[AW-1:0]];
      if (consume) cnt_reg <= cnt_reg + 1'b1;
    end
  end

  assign io_out       = out_reg;
  assign io_out_valid = (state == S_FULL);
  assign frame_cnt    = cnt_reg;
  assign overflow     = ovf_reg;

endmodule

// File: tb/tb_hamming74_encoder_proj.sv
// Scoreboard bench for hamming74_encoder_proj: expected codewords are queued
// at each accepted push and compared against frames consumed at the output.
module tb_hamming74_encoder_proj;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  din = 4'h0;
  logic        din_valid = 1'b0;
  logic        din_ready;
  logic        inj_en = 1'b0;
  logic [2:0]  inj_pos = 3'd7;
  logic [6:0]  io_out;
  logic        io_out_valid;
  logic        io_out_ready = 1'b0;
  logic [15:0] frame_cnt;
  logic        overflow;

  int checks = 0;
  int errors = 0;
  int cyc = 0;

  logic [6:0] exp_q[$];
  logic [6:0] obs_q[$];
  logic [3:0] din_q[$];
  int         obs_t[$];

  hamming74_encoder_proj #(.FIFO_DEPTH(4), .CNT_W(16)) dut (
    .clk(clk), .rst_n(rst_n), .din(din), .din_valid(din_valid),
    .din_ready(din_ready), .inj_en(inj_en), .inj_pos(inj_pos),
    .io_out(io_out), .io_out_valid(io_out_valid), .io_out_ready(io_out_ready),
    .frame_cnt(frame_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [6:0] enc(input logic [3:0] d, input logic ie, input logic [2:0] ip);
    logic [6:0] c;
    c = {d[3], d[2], d[1], d[1]^d[2]^d[3], d[0], d[0]^d[2]^d[3], d[0]^d[1]^d[3]};
    if (ie && ip != 3'd7) c[ip] = ~c[ip];
    return c;
  endfunction

  function automatic logic [3:0] dec(input logic [6:0] cw);
    logic [6:0] c;
    logic [2:0] s;
    c = cw;
    s = {c[3]^c[4]^c[5]^c[6], c[1]^c[2]^c[5]^c[6], c[0]^c[2]^c[4]^c[6]};
    if (s != 3'd0) c[s-1] = ~c[s-1];
    return {c[6], c[5], c[4], c[2]};
  endfunction

  // Handshakes are sampled mid-cycle; inputs only change 1ns after posedge
  always @(negedge clk) begin
    if (rst_n) begin
      if (io_out_valid && io_out_ready) begin
        obs_q.push_back(io_out);
        obs_t.push_back(cyc);
      end
      if (din_valid && din_ready) begin
        exp_q.push_back(enc(din, inj_en, inj_pos));
        din_q.push_back(din);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drain(input int budget, output bit ok);
    io_out_ready = 1'b1;
    din_valid    = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (!io_out_valid && obs_q.size() >= exp_q.size()) break;
      tick();
    end
    ok = !io_out_valid && (obs_q.size() >= exp_q.size());
  endtask

  task automatic clear_queues();
    exp_q.delete();
    obs_q.delete();
    din_q.delete();
    obs_t.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) tick();
    checks++; if (io_out !== 7'h00) begin errors++; $display("FAIL rst_io_out got %h exp 00", io_out); end
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL rst_valid got %b exp 0", io_out_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL rst_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL rst_overflow got %b exp 0", overflow); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL rst_din_ready got %b exp 0", din_ready); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL ready_before_edge got %b exp 0", din_ready); end
    tick();
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL ready_after_edge got %b exp 1", din_ready); end
  endtask

  task automatic test_basic();
    logic [6:0] want [3];
    logic [6:0] o, e;
    int t_prev;
    bit ok;
    want[0] = 7'h00; want[1] = 7'h7F; want[2] = 7'h55;
    io_out_ready = 1'b1;
    din_valid = 1'b1;
    din = 4'h0; tick();
    din = 4'hF; tick();
    din = 4'hB; tick();
    drain(20, ok);
    checks++; if (!ok) begin errors++; $display("FAIL basic_drain_timeout got %0d exp %0d frames", obs_q.size(), 3); end
    checks++; if (obs_q.size() != 3) begin errors++; $display("FAIL basic_count got %0d exp 3", obs_q.size()); end
    t_prev = -1;
    for (int i = 0; i < 3 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== want[i]) begin errors++; $display("FAIL basic_frame%0d got %h exp %h", i, o, want[i]); end
      checks++; if (o !== e) begin errors++; $display("FAIL basic_sb%0d got %h exp %h", i, o, e); end
      if (i > 0) begin
        checks++; if (obs_t[0] != t_prev + 1) begin errors++; $display("FAIL basic_spacing%0d got %0d exp %0d", i, obs_t[0], t_prev + 1); end
      end
      t_prev = obs_t.pop_front();
    end
    checks++; if (frame_cnt !== 16'd3) begin errors++; $display("FAIL basic_frame_cnt got %0d exp 3", frame_cnt); end
    clear_queues();
  endtask

  task automatic test_backpressure();
    logic [3:0] nib [5];
    logic [6:0] o;
    bit ok;
    nib[0] = 4'h3; nib[1] = 4'hA; nib[2] = 4'h6; nib[3] = 4'hC; nib[4] = 4'h1;
    io_out_ready = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      din = nib[i];
      tick();
    end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_full got %b exp 0", din_ready); end
    checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %b exp 1", io_out_valid); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL bp_overflow_early got %b exp 0", overflow); end
    din = 4'h9;
    tick();
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_set got %b exp 1", overflow); end
    din_valid = 1'b0;
    repeat (2) tick();
    checks++; if (io_out !== enc(nib[0], 1'b0, 3'd7)) begin errors++; $display("FAIL bp_hold got %h exp %h", io_out, enc(nib[0], 1'b0, 3'd7)); end
    checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky got %b exp 1", overflow); end
    drain(30, ok);
    checks++; if (!ok) begin errors++; $display("FAIL bp_drain_timeout got %0d exp %0d frames", obs_q.size(), 5); end
    checks++; if (obs_q.size() != 5) begin errors++; $display("FAIL bp_count got %0d exp 5", obs_q.size()); end
    for (int i = 0; i < 5 && obs_q.size() > 0; i++) begin
      o = obs_q.pop_front();
      checks++; if (o !== enc(nib[i], 1'b0, 3'd7)) begin errors++; $display("FAIL bp_frame%0d got %h exp %h", i, o, enc(nib[i], 1'b0, 3'd7)); end
    end
    checks++; if (frame_cnt !== 16'd8) begin errors++; $display("FAIL bp_frame_cnt got %0d exp 8", frame_cnt); end
    clear_queues();
  endtask

  task automatic test_inject();
    logic [6:0] o;
    bit ok;
    io_out_ready = 1'b1;
    din_valid = 1'b1;
    din = 4'h0;
    inj_en = 1'b1;
    inj_pos = 3'd6; tick();
    inj_pos = 3'd7; tick();
    din_valid = 1'b0;
    inj_en = 1'b0;
    drain(20, ok);
    checks++; if (!ok || obs_q.size() != 2) begin errors++; $display("FAIL inj_count got %0d exp 2", obs_q.size()); end
    if (obs_q.size() == 2) begin
      o = obs_q.pop_front();
      checks++; if (o !== 7'h40) begin errors++; $display("FAIL inj_pos6 got %h exp 40", o); end
      checks++; if (dec(o) !== 4'h0) begin errors++; $display("FAIL inj_decode got %h exp 0", dec(o)); end
      o = obs_q.pop_front();
      checks++; if (o !== 7'h00) begin errors++; $display("FAIL inj_pos7 got %h exp 00", o); end
    end
    clear_queues();
  endtask

  task automatic test_stream();
    logic [15:0] cnt0;
    logic [6:0] o, e;
    int t_prev;
    int ready_drops;
    bit ok;
    cnt0 = frame_cnt;
    ready_drops = 0;
    io_out_ready = 1'b1;
    din_valid = 1'b1;
    for (int i = 0; i < 40; i++) begin
      if (!din_ready) ready_drops++;
      din = 4'($urandom_range(0, 15));
      tick();
    end
    checks++; if (16'(frame_cnt - cnt0) !== 16'd38) begin errors++; $display("FAIL stream_frame_cnt got %0d exp 38", 16'(frame_cnt - cnt0)); end
    checks++; if (ready_drops != 0) begin errors++; $display("FAIL stream_ready_drops got %0d exp 0", ready_drops); end
    drain(20, ok);
    checks++; if (!ok || obs_q.size() != 40) begin errors++; $display("FAIL stream_count got %0d exp 40", obs_q.size()); end
    t_prev = -1;
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL stream_frame got %h exp %h", o, e); end
      if (t_prev >= 0) begin
        checks++; if (obs_t[0] != t_prev + 1) begin errors++; $display("FAIL stream_spacing got %0d exp %0d", obs_t[0], t_prev + 1); end
      end
      t_prev = obs_t.pop_front();
    end
    clear_queues();
  endtask

  task automatic test_reset_mid();
    io_out_ready = 1'b0;
    din_valid = 1'b1;
    for (int i = 0; i < 3; i++) begin
      din = 4'(i + 5);
      tick();
    end
    checks++; if (io_out_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %b exp 1", io_out_valid); end
    #2 rst_n = 1'b0;
    din_valid = 1'b0;
    #1;
    checks++; if (io_out !== 7'h00) begin errors++; $display("FAIL mid_io_out got %h exp 00", io_out); end
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %b exp 0", io_out_valid); end
    checks++; if (frame_cnt !== 16'd0) begin errors++; $display("FAIL mid_frame_cnt got %0d exp 0", frame_cnt); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL mid_overflow got %b exp 0", overflow); end
    checks++; if (din_ready !== 1'b0) begin errors++; $display("FAIL mid_din_ready got %b exp 0", din_ready); end
    clear_queues();
    repeat (2) tick();
    #2 rst_n = 1'b1;
    io_out_ready = 1'b1;
    repeat (10) tick();
    checks++; if (obs_q.size() != 0) begin errors++; $display("FAIL mid_stale_frames got %0d exp 0", obs_q.size()); end
    checks++; if (io_out_valid !== 1'b0) begin errors++; $display("FAIL mid_post_valid got %b exp 0", io_out_valid); end
    checks++; if (din_ready !== 1'b1) begin errors++; $display("FAIL mid_post_ready got %b exp 1", din_ready); end
    clear_queues();
  endtask

  task automatic test_random();
    logic [6:0] o, e;
    logic [3:0] d;
    int n;
    bit ok;
    for (int i = 0; i < 300; i++) begin
      din = 4'($urandom_range(0, 15));
      din_valid = ($urandom_range(0, 3) != 0);
      io_out_ready = ($urandom_range(0, 2) != 0);
      tick();
    end
    drain(40, ok);
    checks++; if (!ok) begin errors++; $display("FAIL rand_drain_timeout got %0d exp %0d frames", obs_q.size(), exp_q.size()); end
    n = exp_q.size();
    checks++; if (obs_q.size() != n) begin errors++; $display("FAIL rand_count got %0d exp %0d", obs_q.size(), n); end
    checks++; if (frame_cnt !== 16'(n)) begin errors++; $display("FAIL rand_frame_cnt got %0d exp %0d", frame_cnt, n); end
    while (obs_q.size() > 0 && exp_q.size() > 0) begin
      o = obs_q.pop_front();
      e = exp_q.pop_front();
      d = din_q.pop_front();
      checks++; if (o !== e) begin errors++; $display("FAIL rand_frame got %h exp %h", o, e); end
      checks++; if (dec(o) !== d) begin errors++; $display("FAIL rand_decode got %h exp %h", dec(o), d); end
    end
    clear_queues();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    test_reset();
    test_basic();
    test_backpressure();
    test_inject();
    test_stream();
    test_reset_mid();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
